mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 18 +
 rtl/mem_access_timeout_counter.sv | 30 +++
 rtl/mem_access.sv | 115 +++++++++++
 tb/tb_mem_access.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared processor package: memory-access FSM states and alignment helpers.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } mem_state_t;

  // Doubleword accesses: any of the low three address bits set is misaligned.
  localparam logic [63:0] ALIGN_MASK = 64'h7;

  function automatic logic is_misaligned(input logic [63:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_access_timeout_counter.sv
// Saturating cycle counter that flags when a response wait has used its budget.
module timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // expired marks the last allowed wait cycle, so the FSM leaves after LIMIT cycles.
  assign expired = (count == CW'(LIMIT - 1));

  // Count enabled cycles, holding at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access controller: turns load/store requests into a
// valid/ready bus request plus an optional read response, stalling the pipe.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_M,
  input  logic        memWrite_M,
  input  logic [63:0] aluResult_M,
  input  logic [63:0] writeData_M,
  output logic [63:0] readData_M,
  output logic        stall_M,
  output logic        done_M,
  output logic        error_M,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rdata
);

  mem_state_t  state;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        we_q;
  logic        err_q;
  logic        accept;
  logic        expired;
  logic        access;
  logic        bad_req;

  assign access  = memRead_M | memWrite_M;
  assign bad_req = (memRead_M & memWrite_M) | is_misaligned(aluResult_M);
  assign accept  = (state == REQ) && dmem_req_ready;

  timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (state == WAIT_RSP),
    .expired (expired)
  );

  // Access FSM: latch the request, handshake, wait for data or timeout, report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      readData_M <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            addr_q  <= aluResult_M;
            wdata_q <= writeData_M;
            we_q    <= memWrite_M;
            // Illegal requests never reach the bus; they report straight away.
            if (bad_req) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            state <= we_q ? DONE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response on the final budgeted cycle still wins over the timeout.
          if (dmem_rsp_valid) begin
            readData_M <= dmem_rdata;
            state      <= DONE;
          end else if (expired) begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus request comes from latched values so it stays stable under backpressure.
  assign dmem_req_valid = (state == REQ);
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;

  assign done_M  = (state == DONE);
  assign error_M = (state == DONE) && err_q;

  // Stall rises in the issue cycle itself; reset masks the combinational term.
  assign stall_M = !reset &&
                   (((state == IDLE) && access) || (state == REQ) || (state == WAIT_RSP));

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized traffic
// checked against a transaction-level timing/data model.
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_M;
  logic        memWrite_M;
  logic [63:0] aluResult_M;
  logic [63:0] writeData_M;
  logic [63:0] readData_M;
  logic        stall_M;
  logic        done_M;
  logic        error_M;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rdata;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_rd;

  always #5 clk = ~clk;

  mem_access #(
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .memRead_M      (memRead_M),
    .memWrite_M     (memWrite_M),
    .aluResult_M    (aluResult_M),
    .writeData_M    (writeData_M),
    .readData_M     (readData_M),
    .stall_M        (stall_M),
    .done_M         (done_M),
    .error_M        (error_M),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One access issued at cycle 0 (called just after a rising edge).
  // rdly: REQ cycles with ready low; d: cycles from accept to rsp_valid.
  task automatic run_op(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input int rdly, input int d,
                        input logic [63:0] rdata);
    int nvalid = 0, naccept = 0, nstall = 0, unstable = 0, acc_c = -1, done_c = -1;
    int exp_done;
    logic stall0 = 1'b0, got_err = 1'b0, acc_we = 1'b0, bad, exp_err;
    logic [63:0] first_addr = '0, acc_addr = '0, acc_wdata = '0, got_rd = '0, nxt_rd;

    memRead_M      = rd;
    memWrite_M     = wr;
    aluResult_M    = addr;
    writeData_M    = wdata;
    dmem_req_ready = (rdly == 0);
    dmem_rsp_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) stall0 = stall_M;
      else if (stall_M) nstall++;
      if (dmem_req_valid) begin
        if (nvalid == 0) first_addr = dmem_addr;
        else if (dmem_addr !== first_addr) unstable++;
        nvalid++;
        if (dmem_req_ready) begin
          naccept++;
          acc_c     = c;
          acc_we    = dmem_we;
          acc_addr  = dmem_addr;
          acc_wdata = dmem_wdata;
        end
      end
      if (done_M) begin
        done_c  = c;
        got_err = error_M;
        got_rd  = readData_M;
      end
      @(posedge clk);
      #1;
      if (done_c >= 0) break;
      dmem_req_ready = (nvalid >= rdly);
      dmem_rsp_valid = (acc_c >= 0) && (c + 1 == acc_c + d);
      dmem_rdata     = dmem_rsp_valid ? rdata : {$urandom, $urandom};
    end
    memRead_M      = 1'b0;
    memWrite_M     = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_req_ready = 1'b0;

    // Model: issue at 0, first REQ at 1, accept at 1+rdly, done one cycle later
    // for stores, one cycle after the response for loads, or after TO waits.
    bad     = (rd && wr) || (addr[2:0] != 3'd0);
    nxt_rd  = exp_rd;
    exp_err = 1'b0;
    if (bad) begin
      exp_done = 1;
      exp_err  = 1'b1;
    end else if (wr) begin
      exp_done = rdly + 2;
    end else if (d <= int'(TO)) begin
      exp_done = rdly + 2 + d;
      nxt_rd   = rdata;
    end else begin
      exp_done = rdly + 2 + int'(TO);
      exp_err  = 1'b1;
    end

    check("done_lat", 64'(done_c), 64'(exp_done));
    check("error", 64'(got_err), 64'(exp_err));
    check("read_data", got_rd, nxt_rd);
    check("stall_issue", 64'(stall0), 64'd1);
    check("stall_after", 64'(nstall), 64'(exp_done - 1));
    check("accepts", 64'(naccept), bad ? 64'd0 : 64'd1);
    check("req_cycles", 64'(nvalid), bad ? 64'd0 : 64'(rdly + 1));
    check("addr_stable", 64'(unstable), 64'd0);
    if (!bad && naccept == 1) begin
      check("req_we", 64'(acc_we), 64'(wr));
      check("req_addr", acc_addr, addr);
      check("req_wdata", acc_wdata, wdata);
    end
    exp_rd = nxt_rd;
  endtask

  // Idle cycle with a possible stray response that must be ignored.
  task automatic idle_gap();
    dmem_rsp_valid = 1'($urandom_range(0, 1));
    dmem_rdata     = {$urandom, $urandom};
    @(negedge clk);
    check("idle_rd", readData_M, exp_rd);
    check("idle_done", 64'(done_M), 64'd0);
    @(posedge clk);
    #1;
    dmem_rsp_valid = 1'b0;
  endtask

  // Reset while waiting for a read response, then a late response.
  task automatic reset_in_wait();
    memRead_M      = 1'b1;
    aluResult_M    = 64'h200;
    dmem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    memRead_M = 1'b0;
    @(posedge clk);
    #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_stall", 64'(stall_M), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_rd", readData_M, 64'd0);
    check("rst_stall", 64'(stall_M), 64'd0);
    check("rst_done", 64'(done_M), 64'd0);
    check("rst_error", 64'(error_M), 64'd0);
    check("rst_valid", 64'(dmem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    reset          = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 64'h5555;
    @(negedge clk);
    check("late_rsp_rd", readData_M, 64'd0);
    check("late_rsp_done", 64'(done_M), 64'd0);
    @(posedge clk);
    #1;
    dmem_rsp_valid = 1'b0;
    exp_rd = '0;
  endtask

  initial begin
    logic rd, wr;
    logic [63:0] addr;
    int sel;

    reset          = 1'b0;
    memRead_M      = 1'b0;
    memWrite_M     = 1'b0;
    aluResult_M    = '0;
    writeData_M    = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = '0;
    exp_rd         = '0;

    // Asynchronous reset before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("init_rd", readData_M, 64'd0);
    check("init_stall", 64'(stall_M), 64'd0);
    check("init_done", 64'(done_M), 64'd0);
    check("init_error", 64'(error_M), 64'd0);
    check("init_valid", 64'(dmem_req_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(1'b0, 1'b1, 64'h40, 64'hDEAD, 0, 1, 64'h0);     // store, ready high
    idle_gap();
    run_op(1'b1, 1'b0, 64'h80, 64'h0, 0, 3, 64'h1234);     // load, rsp 3 after accept
    idle_gap();
    run_op(1'b0, 1'b1, 64'h1000, 64'hBEEF, 5, 1, 64'h0);   // 5 cycles of backpressure
    idle_gap();
    run_op(1'b1, 1'b0, 64'h43, 64'h0, 0, 1, 64'h0);        // misaligned load
    idle_gap();
    run_op(1'b1, 1'b1, 64'h48, 64'h0, 0, 1, 64'h0);        // load and store together
    idle_gap();
    run_op(1'b1, 1'b0, 64'h88, 64'h0, 0, 100, 64'hBAD);    // no response: timeout
    idle_gap();
    run_op(1'b1, 1'b0, 64'h90, 64'h0, 0, int'(TO), 64'h77); // response on last cycle
    idle_gap();
    reset_in_wait();

    for (int i = 0; i < 40; i++) begin
      sel  = int'($urandom_range(0, 9));
      addr = {$urandom, $urandom} & ~64'h7;
      rd   = (sel < 4) || (sel == 9);
      wr   = (sel >= 4 && sel < 8) || (sel == 9);
      if (sel == 8) begin
        rd   = 1'($urandom_range(0, 1));
        wr   = !rd;
        addr = addr | 64'($urandom_range(1, 7));
      end
      run_op(rd, wr, addr, {$urandom, $urandom}, int'($urandom_range(0, 3)),
             int'($urandom_range(1, 6)), {$urandom, $urandom});
      if ($urandom_range(0, 1) == 1) idle_gap();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
